// File: rtl/mem_arbiter.sv
// mem_arbiter: NREQ-channel arbiter in front of a single-ported memory.
// Each grant registers the winner's fields toward memory and returns
// exactly one s_ack pulse to that channel.
// The default build uses round-robin fairness.
// Build macro ARB_FIXED_PRIO_EN makes the lowest-indexed requester always win.
module mem_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    s_req,
    input  logic [NREQ*AW-1:0] s_addr,
    input  logic [NREQ-1:0]    s_write,
    input  logic [NREQ*DW-1:0] s_wdata,
    input  logic [NREQ-1:0]    s_extend,
    input  logic [NREQ*2-1:0]  s_width,
    output logic [NREQ-1:0]    s_ack,
    output logic [DW-1:0]      s_rdata,
    output logic               m_req,
    output logic [AW-1:0]      m_addr,
    output logic               m_write,
    output logic [DW-1:0]      m_wdata,
    output logic               m_extend,
    output logic [1:0]         m_width,
    input  logic               m_ack,
    input  logic [DW-1:0]      m_rdata,
    output logic [GW-1:0]      grant_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_grant_en;
    logic            w_resp_en;

    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   r_grant_idx;
    logic            r_m_req;
    logic [AW-1:0]   r_m_addr;
    logic            r_m_write;
    logic [DW-1:0]   r_m_wdata;
    logic            r_m_extend;
    logic [1:0]      r_m_width;
    logic [NREQ-1:0] r_s_ack;
    logic [DW-1:0]   r_s_rdata;

    logic            w_found;
    logic [GW-1:0]   w_winner;
    logic [GW-1:0]   w_cand [NREQ];
    logic [AW-1:0]   w_addr [NREQ];
    logic [DW-1:0]   w_wdata [NREQ];
    logic [1:0]      w_width [NREQ];
    logic [NREQ-1:0] w_onehot;

    // Per-channel field views, rotated search order and ack decode.
    // The search order wraps at NREQ-1, not at a power of two.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_chan
        assign w_addr[gi]   = s_addr[gi*AW +: AW];
        assign w_wdata[gi]  = s_wdata[gi*DW +: DW];
        assign w_width[gi]  = s_width[gi*2 +: 2];
        assign w_onehot[gi] = (r_grant_idx == GW'(gi));
        assign w_cand[gi]   = (int'(r_last_grant) + gi + 1 >= NREQ)
                            ? GW'(int'(r_last_grant) + gi + 1 - NREQ)
                            : GW'(int'(r_last_grant) + gi + 1);
    end

    // Winner selection: scan downward so the first hit in search order wins.
    always_comb begin
        w_found  = |s_req;
        w_winner = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (s_req[i]) begin
                w_winner = GW'(i);
            end
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            if (s_req[w_cand[k-1]]) begin
                w_winner = w_cand[k-1];
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath load strobes; m_ack only matters in BUSY.
    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        w_resp_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_BUSY;
                    w_grant_en   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (m_ack) begin
                    w_state_next = ST_RESP;
                    w_resp_en    = 1'b1;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch the winner on grant, capture the response, clear the ack after one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GW'(NREQ - 1);
            r_grant_idx  <= '0;
            r_m_req      <= 1'b0;
            r_m_addr     <= '0;
            r_m_write    <= 1'b0;
            r_m_wdata    <= '0;
            r_m_extend   <= 1'b0;
            r_m_width    <= 2'd0;
            r_s_ack      <= '0;
            r_s_rdata    <= '0;
        end else begin
            if (w_grant_en) begin
                r_m_req      <= 1'b1;
                r_m_addr     <= w_addr[w_winner];
                r_m_write    <= s_write[w_winner];
                r_m_wdata    <= w_wdata[w_winner];
                r_m_extend   <= s_extend[w_winner];
                r_m_width    <= w_width[w_winner];
                r_grant_idx  <= w_winner;
                r_last_grant <= w_winner;
            end
            if (w_resp_en) begin
                r_m_req   <= 1'b0;
                r_s_rdata <= m_rdata;
                r_s_ack   <= w_onehot;
            end
            if (r_state == ST_RESP) begin
                r_s_ack <= '0;
            end
        end
    end

    assign s_ack     = r_s_ack;
    assign s_rdata   = r_s_rdata;
    assign m_req     = r_m_req;
    assign m_addr    = r_m_addr;
    assign m_write   = r_m_write;
    assign m_wdata   = r_m_wdata;
    assign m_extend  = r_m_extend;
    assign m_width   = r_m_width;
    assign grant_idx = r_grant_idx;

`ifndef SYNTHESIS
    // A granted client must keep its request up until it sees s_ack.
    a_req_held: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_BUSY) |-> s_req[r_grant_idx]);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter (NREQ=3).
// The reference model picks winners directly from the arbitration rule.
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int GW   = $clog2(NREQ);

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    s_req;
    logic [NREQ*AW-1:0] s_addr;
    logic [NREQ-1:0]    s_write;
    logic [NREQ*DW-1:0] s_wdata;
    logic [NREQ-1:0]    s_extend;
    logic [NREQ*2-1:0]  s_width;
    logic [NREQ-1:0]    s_ack;
    logic [DW-1:0]      s_rdata;
    logic               m_req;
    logic [AW-1:0]      m_addr;
    logic               m_write;
    logic [DW-1:0]      m_wdata;
    logic               m_extend;
    logic [1:0]         m_width;
    logic               m_ack;
    logic [DW-1:0]      m_rdata;
    logic [GW-1:0]      grant_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    int model_last = NREQ - 1;

    bit            mem_en     = 1'b0;
    int            mem_lat    = 0;
    logic [DW-1:0] mem_data   = '0;
    bit            force_ack  = 1'b0;
    logic [DW-1:0] force_data = '0;

    logic [AW-1:0] ch_addr  [NREQ];
    logic [DW-1:0] ch_wdata [NREQ];
    logic          ch_write [NREQ];
    logic [1:0]    ch_width [NREQ];
    logic          ch_ext   [NREQ];

    typedef struct {
        int              g;
        logic [AW-1:0]   addr;
        logic            wr;
        logic [DW-1:0]   wd;
        logic [1:0]      wid;
        logic            ext;
        logic [NREQ-1:0] ack;
        logic [DW-1:0]   rd;
        logic            req_at_ack;
        bit              stable;
        bit              timeout;
        int              n_wait;
        int              req_cyc;
    } obs_t;

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_addr(s_addr), .s_write(s_write), .s_wdata(s_wdata),
        .s_extend(s_extend), .s_width(s_width), .s_ack(s_ack), .s_rdata(s_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata),
        .m_extend(m_extend), .m_width(m_width), .m_ack(m_ack), .m_rdata(m_rdata),
        .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks mem_lat cycles after it first sees m_req, once per request.
    initial begin : responder
        int cnt = 0;
        bit acked = 1'b0;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            if (reset || !m_req) begin
                cnt   = 0;
                acked = 1'b0;
            end
            if (force_ack) begin
                m_ack   = 1'b1;
                m_rdata = force_data;
            end else if (mem_en && m_req && !reset && !acked) begin
                if (cnt >= mem_lat) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_data;
                    acked   = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Arbitration rule: first requester after the last grant, with wrap (or lowest index).
    function automatic int model_pick(input logic [NREQ-1:0] req);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
        end
`endif
        return -1;
    endfunction

    task automatic set_chan(input int i, input logic rq, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] w, input logic e);
        ch_addr[i]  = a;
        ch_wdata[i] = d;
        ch_write[i] = wr;
        ch_width[i] = w;
        ch_ext[i]   = e;
        s_req[i]    = rq;
        s_write[i]  = wr;
        s_extend[i] = e;
        s_addr[i*AW +: AW]  = a;
        s_wdata[i*DW +: DW] = d;
        s_width[i*2 +: 2]   = w;
    endtask

    task automatic rand_chan(input int i, input logic rq);
        set_chan(i, rq, 1'($urandom), AW'($urandom), DW'($urandom),
                 2'($urandom_range(0, 2)), 1'($urandom));
    endtask

    // Waits for the next grant and its s_ack, recording what the DUT showed; returns at the ack negedge.
    task automatic serve(output obs_t o);
        int n = 0;
        o = '{default: 0};
        o.stable = 1'b1;
        @(negedge clk);
        n = 1;
        while (!m_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        o.n_wait = n;
        if (!m_req) begin
            o.timeout = 1'b1;
            return;
        end
        o.g    = int'(grant_idx);
        o.addr = m_addr;
        o.wr   = m_write;
        o.wd   = m_wdata;
        o.wid  = m_width;
        o.ext  = m_extend;
        while (s_ack == '0 && n < 100) begin
            if (m_req) begin
                o.req_cyc++;
                if (m_addr !== o.addr || m_write !== o.wr || m_wdata !== o.wd ||
                    m_width !== o.wid || m_extend !== o.ext || int'(grant_idx) != o.g)
                    o.stable = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (s_ack == '0) o.timeout = 1'b1;
        o.ack        = s_ack;
        o.rd         = s_rdata;
        o.req_at_ack = m_req;
        n_txn++;
        $display("txn %0d: ch=%0d addr=%h write=%0b wdata=%h width=%0d ack=%b rdata=%h",
                 n_txn, o.g, o.addr, o.wr, o.wd, o.wid, o.ack, o.rd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m_req, s_ack, grant_idx, m_write, m_extend, m_width} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: m_req=%b s_ack=%b grant=%0d expected all 0", m_req, s_ack, grant_idx);
        end
        n_checks++;
        if ({m_addr, m_wdata, s_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected 0", m_addr, m_wdata, s_rdata);
        end
        reset = 1'b0;
        model_last = NREQ - 1;
    endtask

    task automatic test_single_read();
        obs_t o;
        mem_en = 1'b1;
        mem_lat = 1;
        mem_data = 32'hDEAD_BEEF;
        set_chan(0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        serve(o);
        n_checks++;
        if (o.timeout || o.n_wait != 1 || o.g != 0) begin
            n_fail++;
            $display("FAIL read_grant: timeout=%0d wait=%0d ch=%0d expected 0/1/0", o.timeout, o.n_wait, o.g);
        end
        n_checks++;
        if (o.addr !== 32'h100 || o.wr !== 1'b0 || !o.stable || o.req_cyc != 2) begin
            n_fail++;
            $display("FAIL read_mreq: addr=%h wr=%b stable=%0d req_cycles=%0d expected 100/0/1/2",
                     o.addr, o.wr, o.stable, o.req_cyc);
        end
        n_checks++;
        if (o.ack !== 3'b001 || o.rd !== 32'hDEAD_BEEF || o.req_at_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp: ack=%b rdata=%h m_req=%b expected 001/deadbeef/0", o.ack, o.rd, o.req_at_ack);
        end
        model_last = 0;
        s_req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_ack !== '0) begin
            n_fail++;
            $display("FAIL read_ack_pulse: s_ack=%b expected 000", s_ack);
        end
    endtask

    task automatic test_write();
        obs_t o;
        mem_lat = 3;
        mem_data = 32'h5555_AAAA;
        set_chan(1, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 2'd2, 1'b0);
        serve(o);
        n_checks++;
        if (o.timeout || o.g != 1 || o.ack !== 3'b010) begin
            n_fail++;
            $display("FAIL write_grant: timeout=%0d ch=%0d ack=%b expected ch 1 ack 010", o.timeout, o.g, o.ack);
        end
        n_checks++;
        if ({o.addr, o.wr, o.wd, o.wid} !== {32'h2000, 1'b1, 32'h1234_5678, 2'd2} || !o.stable || o.req_cyc != 4) begin
            n_fail++;
            $display("FAIL write_fields: addr=%h wr=%b wdata=%h width=%0d stable=%0d req_cycles=%0d",
                     o.addr, o.wr, o.wd, o.wid, o.stable, o.req_cyc);
        end
        model_last = 1;
        s_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp;
        logic [NREQ-1:0] e1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) rand_chan(i, 1'b1);
        for (int t = 0; t < 2 * NREQ + 1; t++) begin
            mem_lat  = int'($urandom_range(0, 3));
            mem_data = DW'($urandom);
            exp = model_pick(s_req);
            serve(o);
            e1 = '0;
            e1[exp] = 1'b1;
            n_checks++;
            if (o.timeout || o.g != exp || o.ack !== e1 || o.rd !== mem_data ||
                o.addr !== ch_addr[exp] || o.req_cyc != mem_lat + 1) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: ch=%0d ack=%b rdata=%h addr=%h, expected ch=%0d ack=%b rdata=%h addr=%h",
                         t, o.g, o.ack, o.rd, o.addr, exp, e1, mem_data, ch_addr[exp]);
            end
            model_last = exp;
            rand_chan(exp, 1'b1);
            @(negedge clk);
        end
        s_req = '0;
        @(negedge clk);
    endtask

    task automatic test_ack_in_idle();
        obs_t o;
        logic [DW-1:0] prev;
        prev = s_rdata;
        force_data = 32'hCAFE_F00D;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_ack !== '0 || m_req !== 1'b0 || s_rdata !== prev) begin
            n_fail++;
            $display("FAIL idle_ack: s_ack=%b m_req=%b rdata=%h expected 000/0/%h", s_ack, m_req, s_rdata, prev);
        end
        mem_lat = 0;
        mem_data = 32'h0BAD_C0DE;
        set_chan(2, 1'b1, 1'b0, 32'h300, 32'h0, 2'd1, 1'b1);
        serve(o);
        n_checks++;
        if (o.timeout || o.n_wait != 1 || o.g != 2 || o.ack !== 3'b100 || o.rd !== 32'h0BAD_C0DE) begin
            n_fail++;
            $display("FAIL idle_after: wait=%0d ch=%0d ack=%b rdata=%h expected 1/2/100/0badc0de",
                     o.n_wait, o.g, o.ack, o.rd);
        end
        model_last = 2;
        s_req = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        obs_t o;
        int n = 0;
        mem_en = 1'b0;
        set_chan(1, 1'b1, 1'b1, 32'h440, 32'h7777_0001, 2'd0, 1'b0);
        @(negedge clk);
        while (!m_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (m_req !== 1'b1 || int'(grant_idx) != 1) begin
            n_fail++;
            $display("FAIL busy_before_reset: m_req=%b grant=%0d expected 1/1", m_req, grant_idx);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (m_req !== 1'b0 || s_ack !== '0 || grant_idx !== '0) begin
            n_fail++;
            $display("FAIL async_reset: m_req=%b s_ack=%b grant=%0d expected 0/000/0", m_req, s_ack, grant_idx);
        end
        for (int i = 0; i < NREQ; i++) rand_chan(i, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        model_last = NREQ - 1;
        mem_en = 1'b1;
        mem_lat = 1;
        mem_data = DW'($urandom);
        serve(o);
        n_checks++;
        if (o.timeout || o.g != 0 || o.ack !== 3'b001) begin
            n_fail++;
            $display("FAIL post_reset_grant: ch=%0d ack=%b expected 0/001", o.g, o.ack);
        end
        model_last = 0;
        s_req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        obs_t o;
        int exp;
        logic [NREQ-1:0] e1;
        for (int i = 0; i < NREQ; i++) rand_chan(i, 1'($urandom));
        for (int t = 0; t < 40; t++) begin
            if (s_req == '0) rand_chan(int'($urandom_range(0, NREQ - 1)), 1'b1);
            mem_lat  = int'($urandom_range(0, 3));
            mem_data = DW'($urandom);
            exp = model_pick(s_req);
            serve(o);
            e1 = '0;
            e1[exp] = 1'b1;
            n_checks++;
            if (o.timeout || o.g != exp || o.ack !== e1 || o.rd !== mem_data) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: ch=%0d ack=%b rdata=%h, expected ch=%0d ack=%b rdata=%h",
                         t, o.g, o.ack, o.rd, exp, e1, mem_data);
            end
            n_checks++;
            if ({o.addr, o.wr, o.wd, o.wid, o.ext} !== {ch_addr[exp], ch_write[exp], ch_wdata[exp], ch_width[exp], ch_ext[exp]}
                || !o.stable || o.req_cyc != mem_lat + 1) begin
                n_fail++;
                $display("FAIL rand_fields[%0d]: addr=%h wr=%b wdata=%h width=%0d ext=%b stable=%0d req_cycles=%0d, expected addr=%h wr=%b wdata=%h width=%0d ext=%b req_cycles=%0d",
                         t, o.addr, o.wr, o.wd, o.wid, o.ext, o.stable, o.req_cyc,
                         ch_addr[exp], ch_write[exp], ch_wdata[exp], ch_width[exp], ch_ext[exp], mem_lat + 1);
            end
            model_last = exp;
            rand_chan(exp, 1'($urandom));
            for (int i = 0; i < NREQ; i++) begin
                if (!s_req[i] && $urandom_range(0, 2) == 0) rand_chan(i, 1'b1);
            end
            @(negedge clk);
            n_checks++;
            if (s_ack !== '0) begin
                n_fail++;
                $display("FAIL rand_ack_pulse[%0d]: s_ack=%b expected 000", t, s_ack);
            end
        end
        s_req = '0;
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        s_req    = '0;
        s_addr   = '0;
        s_write  = '0;
        s_wdata  = '0;
        s_extend = '0;
        s_width  = '0;
        for (int i = 0; i < NREQ; i++) set_chan(i, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_ack_in_idle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-requester arbiter between pipeline memory clients (fetch, data memory stage, future DMA/debug ports) and the single-ported `memory` block.
- Generalises the current fixed two-client fetch/mem hookup to NREQ channels with round-robin fairness.
- Each transaction is registered toward memory, and exactly one response is returned to the granted client.

Parameters:
NREQ, 2, number of requester channels (>=2); index 0 = fetch by convention
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
s_req  input  NREQ  per-channel request; held high with stable fields until that channel's s_ack
s_addr  input  NREQ*AW  per-channel address; channel i at bits [i*AW +: AW]
s_write  input  NREQ  per-channel write enable (0 = read)
s_wdata  input  NREQ*DW  per-channel write data
s_extend  input  NREQ  per-channel sign-extend-on-read flag
s_width  input  NREQ*2  per-channel access width (0 byte, 1 half, 2 word)
s_ack  output  NREQ  one-hot, one-cycle response pulse
s_rdata  output  DW  read data, broadcast; valid while any s_ack bit is high
m_req  output  1  request to memory
m_addr  output  AW  registered address of the granted channel
m_write  output  1  registered write flag
m_wdata  output  DW  registered write data
m_extend  output  1  registered extend flag
m_width  output  2  registered width
m_ack  input  1  memory completion pulse
m_rdata  input  DW  memory read data, valid with m_ack
grant_idx  output  clog2(NREQ)  index of the channel currently owning memory (debug/forwarding)

Behaviour:
- Reset (asynchronous, any cycle including mid-transaction):
  - state=IDLE; all outputs 0; last_grant=NREQ-1, so channel 0 wins first.
  - Any in-flight memory transaction is abandoned; memory is reset in the same domain.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any s_req bit is set, pick the winner by round-robin: first set bit searching from (last_grant+1) mod NREQ upward, with wrap-around.
  - Latch the winner's fields into the m_* registers; grant_idx=winner; last_grant=winner; m_req<=1; go to BUSY.
  - If no s_req bit is set, stay in IDLE with m_req=0.
- BUSY:
  - m_req and the m_* fields are held constant.
  - On m_ack: m_req<=0, s_rdata<=m_rdata, s_ack[grant_idx]<=1, go to RESP.
  - m_ack is ignored in IDLE and RESP.
- RESP:
  - s_ack is high for exactly this one cycle, then s_ack<=0 and go to IDLE.
  - The client samples s_ack and drops or changes s_req at that edge, so no re-grant of a stale request is possible.
- Latency:
  - s_req sampled at edge 0 gives m_req high from edge 1.
  - m_ack seen at edge k gives s_ack at edge k+1; IDLE at k+2.
  - Minimum back-to-back period is 3 cycles plus memory latency.
- Ordering and fairness:
  - Exactly one outstanding transaction.
  - Requests arriving while BUSY/RESP wait; none is dropped.
  - No channel waits more than NREQ-1 grants.
- s_rdata holds its last value outside RESP; for writes it is the m_rdata value returned with m_ack (don't-care).
- Dropping s_req before s_ack is a protocol violation: the arbiter completes the transaction and still pulses s_ack. Simulation-only assertion flags it.
- Simultaneous s_req on all channels: served strictly in rotating order.
- NREQ not a power of two: the pointer wraps at NREQ-1 to 0, never at 2^clog2.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: IDLE always grants the lowest-indexed set s_req bit. last_grant is still updated but ignored. Intended for giving the data-memory client priority by index mapping.
- Undefined: round-robin as above.
- All other timing is identical.

Test Plan:
1. Reset, then s_req=01 with addr0=0x100 read; memory acks 2 cycles after m_req with rdata=0xDEADBEEF -> m_req high cycles 1-3, m_addr=0x100, s_ack=01 for one cycle at cycle 4, s_rdata=0xDEADBEEF.
2. NREQ=2, both s_req held high for 4 transactions -> grant sequence 0,1,0,1; with ARB_FIXED_PRIO_EN, sequence 0,0,0,0 while s_req[0] stays high.
3. Channel 1 write addr=0x2000, wdata=0x12345678, width=2 -> m_write=1, m_wdata=0x12345678, m_width=2 held constant until m_ack; s_ack=10.
4. NREQ=3, s_req=111 after last_grant=2 -> grants 0,1,2, then wrap to 0; grant_idx matches each m_req.
5. Assert reset while BUSY with m_ack pending -> m_req, s_ack, grant_idx go 0 immediately (asynchronously); after release, the first grant goes to channel 0.
6. m_ack asserted in IDLE with no request -> no s_ack, state unchanged.
